imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory: it accepts a byte stream (length header followed by little-endian instruction words), assembles 32-bit words and writes them sequentially into the instruction RAM's write port. While loading it holds the core in reset. It sits between the host byte link (UART RX or a testbench driver) and the instruction memory, which the fetch stage reads combinationally at `adr >> 2`.

## Interface

Parameters:
- `ROM_DEPTH`, default 10: word-address bits of the target memory; capacity is `1 << ROM_DEPTH` words.
- `BASE_ADR`, default 32'h0000_0000: byte address of the first written word; must be word-aligned.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `byte_valid`  in  1  `byte_data` holds a valid byte.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `byte_valid && byte_ready`.
- `we`  out  1  write strobe to the instruction memory, one cycle per word.
- `wadr`  out  32  byte address of the write; always word-aligned.
- `wdata`  out  32  instruction word.
- `busy`  out  1  load in progress; drives the core's hold/reset.
- `done`  out  1  last load completed successfully; level output.
- `err`  out  1  last load aborted because the length exceeded capacity; level output.

## Operation

- Stream format: 4 length bytes giving N (number of words, little-endian), then N×4 data bytes. Each word is little-endian: the first byte goes to `wdata[7:0]`.
- FSM states and transitions:
  - IDLE: waits for `start`, then goes to LEN.
  - LEN: collects 4 bytes into N. After the 4th byte: if N==0, go to DONE; if N > `1 << ROM_DEPTH`, go to ERR; otherwise go to DATA.
  - DATA: collects 4 bytes. After the 4th byte, go to WRITE.
  - WRITE: one cycle with `we`=1 and word index incremented. If index==N after the increment, go to DONE; otherwise go back to DATA.
  - DONE and ERR: wait for `start`, then go to LEN with counters, `done` and `err` cleared.
- `byte_ready`=1 only in LEN and DATA. Bytes presented in any other state are not consumed.
- `wadr` = `BASE_ADR` + 4×index. Index width is `ROM_DEPTH`+1 bits so that N == capacity is legal; N is held at 32 bits.
- Byte counter is 2 bits and wraps 3→0 on the 4th byte. The shift register loads `{byte, sr[31:8]}` on each transfer.
- `start` outside IDLE/DONE/ERR is ignored; a load is never restarted mid-stream.
- `busy`=1 in LEN, DATA and WRITE.
- `wdata` and `wadr` are stable while `we`=1. When `we`=0 they hold their last value, which has no meaning.

## Timing

- Reset values: FSM=IDLE, `byte_ready`=0, `we`=0, `wadr`=`BASE_ADR`, `wdata`=0, `busy`=0, `done`=0, `err`=0. All counters are 0.
- Reset asserted mid-load returns to IDLE immediately; no further `we` pulses. Memory contents already written are untouched.
- `start` at cycle t gives `busy`=1 and `byte_ready`=1 at t+1.
- 4th data byte accepted at edge t gives `we`=1 during cycle t+1, with `byte_ready`=0 for that cycle.
- Maximum throughput is one word per 5 cycles.
- `done` or `err` rises, and `busy` falls, in the cycle after the final WRITE or the decisive 4th length byte.
- `byte_valid` may drop at any point. The loader stalls with no timeout and counters keep their state.

## Structure

- Shared package/header holds:
  - the state encodings (IDLE, LEN, DATA, WRITE, DONE, ERR);
  - the `ROM_DEPTH` default, so the loader and the instruction memory agree on capacity;
  - the word-size constant (4 bytes).
- One natural sub-module, `word_assembler`: the 2-bit byte counter plus 32-bit shift register. It outputs `word` and a `word_full` pulse and is reused for both the length field and the data words.
- Top level contains the FSM, index counter and output registers.

## Test plan

- Reset, then `start`, then bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 → two `we` pulses: (`wadr`=0x0, `wdata`=0x0000_0013) and (`wadr`=0x4, `wdata`=0x0010_0093). Then `done`=1, `busy`=0.
- Length 00 00 00 00 → no `we`; `done`=1 one cycle after the 4th byte.
- Length 01 04 00 00 (1025, exceeds 1024) → `err`=1, no `we`, `byte_ready`=0 afterward. A new `start` clears `err`.
- Length = 1024 with a counting pattern, `byte_valid` toggled randomly → exactly 1024 writes; the last has `wadr`=0xFFC. A readback of the memory matches.
- `rst_n` pulled low after 2 of 4 data bytes → outputs return to reset values at once. A subsequent full load with `start` succeeds from byte 0.
- `start` pulsed during DATA → ignored: the word sequence and addresses are unchanged.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader and the
// instruction memory it fills.
package imem_loader_pkg;

   // Loader FSM states.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   // Word-address bits of the instruction memory (capacity 1 << depth words);
   // the loader and the memory both take their default from here.
   localparam int ROM_DEPTH_DEF = 10;

   // Bytes per instruction word.
   localparam int WORD_BYTES = 4;

endpackage : imem_loader_pkg

// File: rtl/imem_loader_word.sv
// word_assembler: packs four little-endian stream bytes into a 32-bit word.
// Used for the length header as well as for every instruction word.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        push,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0]  cnt;
   logic [31:0] sr;

   // The completed word includes the byte arriving this cycle, so the FSM can
   // capture it on the same edge that accepts the 4th byte.
   assign word      = {byte_data, sr[31:8]};
   assign word_full = push && (cnt == 2'(WORD_BYTES - 1));

   // Byte counter (wraps 3 -> 0 on the 4th byte) and shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sr  <= '0;
      end else if (clr) begin
         cnt <= '0;
         sr  <= '0;
      end else if (push) begin
         // NOTE: non-blocking assignments for all sequential state, so every
         // register samples pre-edge values regardless of statement order.
         sr  <= word;
         cnt <= cnt + 2'd1;
      end
   end

endmodule : word_assembler

// File: rtl/imem_loader.sv
// imem_loader: receives a length header plus little-endian words from the host
// byte link and writes them sequentially to the instruction memory, holding
// the core (busy) while the load is in progress.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          ROM_DEPTH = ROM_DEPTH_DEF,
   parameter logic [31:0] BASE_ADR  = 32'h0000_0000   // must be word-aligned
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        we,
   output logic [31:0] wadr,
   output logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // One extra bit so that capacity itself is a representable length.
   localparam logic [32:0] CAPACITY = 33'd1 << ROM_DEPTH;

   state_t               state;
   logic [ROM_DEPTH:0]   idx;
   logic [ROM_DEPTH:0]   idx_inc;
   logic [31:0]          n_words;
   logic                 push;
   logic                 start_ok;
   logic [31:0]          asm_word;
   logic                 word_full;

   assign push     = byte_valid && byte_ready;
   assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
   assign idx_inc  = idx + (ROM_DEPTH + 1)'(1);

   word_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (start_ok),
      .push      (push),
      .byte_data (byte_data),
      .word      (asm_word),
      .word_full (word_full)
   );

   // Loader FSM with registered handshake, write-port and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         idx        <= '0;
         n_words    <= '0;
         byte_ready <= 1'b0;
         we         <= 1'b0;
         wadr       <= BASE_ADR;
         wdata      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start_ok) begin
                  state      <= S_LEN;
                  idx        <= '0;
                  n_words    <= '0;
                  byte_ready <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  err        <= 1'b0;
               end
            end
            S_LEN: begin
               if (word_full) begin
                  n_words <= asm_word;
                  if (asm_word == 32'd0) begin
                     state      <= S_DONE;
                     byte_ready <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                  end else if ({1'b0, asm_word} > CAPACITY) begin
                     state      <= S_ERR;
                     byte_ready <= 1'b0;
                     busy       <= 1'b0;
                     err        <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (word_full) begin
                  state      <= S_WRITE;
                  byte_ready <= 1'b0;
                  we         <= 1'b1;
                  wdata      <= asm_word;
                  wadr       <= BASE_ADR + 32'(idx) * WORD_BYTES;
               end
            end
            S_WRITE: begin
               we  <= 1'b0;
               idx <= idx_inc;
               if (32'(idx_inc) == n_words) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state      <= S_DATA;
                  byte_ready <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: stimulus pushes expected writes into a
// queue, a monitor pops and compares them whenever we is asserted.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_ready;
   logic        we;
   logic [31:0] wadr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] tx_words[$];
   logic [31:0] mem [0:1023];
   logic [31:0] last_wadr = '0;
   int          n_vec = 0;
   int          n_err = 0;
   int          n_writes = 0;

   imem_loader #(.ROM_DEPTH(10), .BASE_ADR(32'h0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .we         (we),
      .wadr       (wadr),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse is compared against the scoreboard head and
   // stored into the bench's model of the instruction memory.
   always @(negedge clk) begin
      if (rst_n && we) begin
         n_writes++;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got adr 0x%08h data 0x%08h, expected no write", wadr, wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (wadr !== e.adr || wdata !== e.data) begin
               n_err++;
               $display("FAIL write: got adr 0x%08h data 0x%08h, expected adr 0x%08h data 0x%08h",
                        wadr, wdata, e.adr, e.data);
            end
         end
         mem[wadr[11:2]] = wdata;
         last_wadr = wadr;
      end
   end

   // Presents one byte (optionally after random idle cycles) and returns at
   // the falling edge after it was accepted.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int t;
      if (gaps) begin
         byte_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      while (!byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!byte_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL byte_ready_timeout: got 0, expected 1 within 50 cycles");
      end
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
   endtask

   task automatic pulse_start(input string name);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "_busy"}, 32'(busy), 32'd1);
      check({name, "_ready"}, 32'(byte_ready), 32'd1);
   endtask

   // Full load of tx_words; a start pulse is injected in the middle of word
   // start_word (negative disables it).
   task automatic run_load(input string name, input bit gaps, input int start_word);
      int n;
      n = tx_words.size();
      for (int i = 0; i < n; i++) exp_q.push_back('{adr: 32'(i) * 4, data: tx_words[i]});
      pulse_start(name);
      send_word(32'(n), gaps);
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 4; b++) begin
            send_byte(tx_words[i][8*b +: 8], gaps);
            if (i == start_word && b == 1) begin
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
            end
         end
         if (i < 3) begin
            check({name, "_we_after_4th"}, 32'(we), 32'd1);
            check({name, "_ready_in_write"}, 32'(byte_ready), 32'd0);
         end
      end
      @(negedge clk);
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_busy_low"}, 32'(busy), 32'd0);
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ready"}, 32'(byte_ready), 32'd0);
      check({name, "_we"}, 32'(we), 32'd0);
      check({name, "_wadr"}, wadr, 32'h0);
      check({name, "_wdata"}, wdata, 32'h0);
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_done"}, 32'(done), 32'd0);
      check({name, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w0;
      // Reset state.
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Two-word load from the test plan.
      tx_words = '{32'h0000_0013, 32'h0010_0093};
      run_load("basic", 1'b0, -1);
      check("basic_mem0", mem[0], 32'h0000_0013);
      check("basic_mem1", mem[1], 32'h0010_0093);

      // Zero length: done one cycle after the 4th length byte.
      w0 = n_writes;
      pulse_start("zero");
      check("zero_done_cleared", 32'(done), 32'd0);
      send_word(32'h0, 1'b0);
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_no_we", 32'(n_writes - w0), 32'd0);

      // Length 1025 exceeds capacity.
      pulse_start("over");
      send_word(32'h0000_0401, 1'b0);
      check("over_err", 32'(err), 32'd1);
      check("over_busy", 32'(busy), 32'd0);
      check("over_ready", 32'(byte_ready), 32'd0);
      check("over_done", 32'(done), 32'd0);
      byte_valid = 1'b1;
      byte_data  = 8'hAA;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      check("over_still_not_ready", 32'(byte_ready), 32'd0);
      check("over_no_we", 32'(n_writes - w0), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("over_err_cleared", 32'(err), 32'd0);
      // Finish this load with length 0 to return to DONE.
      send_word(32'h0, 1'b0);
      check("over_recover_done", 32'(done), 32'd1);

      // Full-capacity load with a counting pattern and random valid gaps.
      tx_words.delete();
      for (int i = 0; i < 1024; i++) tx_words.push_back(32'hC0DE_0000 + 32'(i) * 32'h0001_0003);
      w0 = n_writes;
      run_load("full", 1'b1, -1);
      check("full_write_count", 32'(n_writes - w0), 32'd1024);
      check("full_last_wadr", last_wadr, 32'h0000_0FFC);
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 1024; i++)
            if (mem[i] !== 32'hC0DE_0000 + 32'(i) * 32'h0001_0003) bad++;
         check("full_readback_bad_words", 32'(bad), 32'd0);
      end

      // Reset after 2 of 4 data bytes: outputs back to reset values at once.
      w0 = n_writes;
      pulse_start("abort");
      send_word(32'd1, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_no_we", 32'(n_writes - w0), 32'd0);
      check("abort_mem_untouched", mem[0], 32'hC0DE_0000);

      // Subsequent full load succeeds from byte 0; start mid-word is ignored.
      tx_words = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
      run_load("restart", 1'b0, 1);
      check("restart_mem2", mem[2], 32'h89AB_CDEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_imem_loader
